// File: rtl/pagerank_pkg.sv
// Shared types and helpers for the PageRank contribution accumulator.
package pagerank_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIV  = 3'd1,
    ST_ACC  = 3'd2,
    ST_DAMP = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  localparam logic [15:0] DAMP_Q16 = 16'hD99A;

  // Widest datapath the saturating adder supports.
  localparam int SAT_W = 64;

  function automatic int pr_qw(input int width, input int frac);
    return width + frac;
  endfunction

  // Returns {overflow, value}; the value is clamped to 2^w-1.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                             input logic [SAT_W-1:0] b,
                                             input int unsigned      w);
    logic [SAT_W:0] s;
    logic [SAT_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ({{SAT_W{1'b0}}, 1'b1} << w) - {{SAT_W{1'b0}}, 1'b1};
    if (s > lim) return {1'b1, lim[SAT_W-1:0]};
    return {1'b0, s[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/pagerank_reduce_acc_divider.sv
// Restoring radix-2 divider: (dividend << FRAC_BITS) / divisor, one quotient bit per cycle.
module seq_divider
  import pagerank_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n_i,
  input  logic                                  start_i,
  input  logic [WIDTH-1:0]                      dividend_i,
  input  logic [WIDTH-1:0]                      divisor_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [pr_qw(WIDTH, FRAC_BITS)-1:0]    quotient_o
);

  localparam int QW = pr_qw(WIDTH, FRAC_BITS);
  localparam int CW = $clog2(QW + 1);

  logic [QW-1:0]    dvd_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_next;
  logic             qbit;

  always_comb begin
    rem_shift = {rem_q, dvd_q[QW-1]};
    qbit      = (rem_shift >= {1'b0, dvs_q});
    rem_next  = qbit ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
  end

  // The dividend register shifts the quotient in from the bottom as it drains.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      dvd_q  <= QW'(dividend_i) << FRAC_BITS;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      cnt_q  <= CW'(QW);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      dvd_q  <= {dvd_q[QW-2:0], qbit};
      rem_q  <= WIDTH'(rem_next);
      cnt_q  <= cnt_q - CW'(1);
      busy_q <= (cnt_q != CW'(1));
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CW'(1));
  assign quotient_o = dvd_q;

endmodule

// File: rtl/pagerank_reduce_acc.sv
// Streaming PageRank group accumulator: divide each (rank, degree) tuple, saturate-sum the group.
// Optional damping stage enabled by defining PAGERANK_DAMPING_EN.
module pagerank_reduce_acc
  import pagerank_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter int              FRAC_BITS = 16,
  parameter int              CNT_W     = 16,
  parameter logic [15:0]     DAMP      = DAMP_Q16,
  parameter logic [WIDTH-1:0] BASE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_page_rank,
  input  logic [WIDTH-1:0] in_out_deg,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero_deg,
  output logic             out_ovf
);

  localparam int            QW   = pr_qw(WIDTH, FRAC_BITS);
  localparam logic [QW-1:0] QMAX = QW'({WIDTH{1'b1}});

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             last_q, last_d;
  logic             tz_q, tz_d;

  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [QW-1:0]    div_quot;

  seq_divider #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_div (
    .clk        (clk),
    .rst_n_i    (rst_n),
    .start_i    (div_start),
    .dividend_i (in_page_rank),
    .divisor_i  (in_out_deg),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  logic             q_big;
  logic [WIDTH-1:0] q_val;
  logic [SAT_W:0]   acc_add;

  always_comb begin
    q_big   = !tz_q && (div_quot > QMAX);
    q_val   = tz_q ? '0 : (q_big ? '1 : div_quot[WIDTH-1:0]);
    acc_add = sat_add(SAT_W'(sum_q), SAT_W'(q_val), WIDTH);
  end

`ifdef PAGERANK_DAMPING_EN
  logic [WIDTH+15:0] damp_prod;
  logic [WIDTH-1:0]  damp_scaled;
  logic [SAT_W:0]    damp_add;

  always_comb begin
    damp_prod   = (WIDTH+16)'(sum_q) * (WIDTH+16)'(DAMP);
    damp_scaled = WIDTH'(damp_prod >> 16);
    damp_add    = sat_add(SAT_W'(BASE), SAT_W'(damp_scaled), WIDTH);
  end
`endif

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    last_d    = last_q;
    tz_d      = tz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    div_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          last_d = in_last;
          cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (in_out_deg == '0) begin
            zero_d  = 1'b1;
            tz_d    = 1'b1;
            state_d = ST_ACC;
          end else begin
            tz_d      = 1'b0;
            div_start = 1'b1;
            state_d   = ST_DIV;
          end
        end
      end
      // An idle divider here can only mean a lost start; fall through rather than stall.
      ST_DIV: begin
        if (div_done || !div_busy) state_d = ST_ACC;
      end
      ST_ACC: begin
        sum_d = WIDTH'(acc_add);
        ovf_d = ovf_q | acc_add[SAT_W] | q_big;
`ifdef PAGERANK_DAMPING_EN
        if (last_q) state_d = ST_DAMP;
`else
        if (last_q) state_d = ST_OUT;
`endif
        else        state_d = ST_IDLE;
      end
`ifdef PAGERANK_DAMPING_EN
      ST_DAMP: begin
        sum_d   = WIDTH'(damp_add);
        ovf_d   = ovf_q | damp_add[SAT_W];
        state_d = ST_OUT;
      end
`endif
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          sum_d   = '0;
          cnt_d   = '0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          last_d  = 1'b0;
          tz_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
      tz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      tz_q    <= tz_d;
    end
  end

  assign out_sum      = sum_q;
  assign out_count    = cnt_q;
  assign out_zero_deg = zero_q;
  assign out_ovf      = ovf_q;

endmodule

// File: tb/tb_pagerank_reduce_acc.sv
// Directed bench: integer-mode and Q16.16 instances driven from a tuple table.
module tb_pagerank_reduce_acc;

  localparam int LIM = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [31:0] in_pr    [2];
  logic [31:0] in_deg   [2];
  logic        in_last  [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [31:0] out_sum  [2];
  logic        out_zero [2];
  logic        out_ovf  [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pagerank_reduce_acc #(.WIDTH(32), .FRAC_BITS(0), .CNT_W(16)) u_dut_int (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_page_rank(in_pr[0]), .in_out_deg(in_deg[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(out_sum[0]), .out_count(cnt0),
    .out_zero_deg(out_zero[0]), .out_ovf(out_ovf[0])
  );

  pagerank_reduce_acc #(.WIDTH(32), .FRAC_BITS(16), .CNT_W(2)) u_dut_frac (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_page_rank(in_pr[1]), .in_out_deg(in_deg[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(out_sum[1]), .out_count(cnt1),
    .out_zero_deg(out_zero[1]), .out_ovf(out_ovf[1])
  );

  typedef struct {
    int          inst;
    logic [31:0] pr;
    logic [31:0] deg;
    bit          last;
    logic [31:0] esum;
    int          ecnt;
    bit          ez;
    bit          eo;
    int          hold;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int inst, logic [31:0] pr, logic [31:0] deg, bit last,
                              logic [31:0] esum, int ecnt, bit ez, bit eo, int hold);
    vec_t v;
    v.inst = inst; v.pr = pr; v.deg = deg; v.last = last;
    v.esum = esum; v.ecnt = ecnt; v.ez = ez; v.eo = eo; v.hold = hold;
    return v;
  endfunction

  function automatic logic [15:0] cnt_of(int i);
    return (i == 0) ? cnt0 : {14'b0, cnt1};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic send(int i, logic [31:0] pr, logic [31:0] deg, bit last);
    in_valid[i] = 1'b1; in_pr[i] = pr; in_deg[i] = deg; in_last[i] = last;
    @(posedge clk); #1;
    in_valid[i] = 1'b0; in_pr[i] = '0; in_deg[i] = '0; in_last[i] = 1'b0;
  endtask

  task automatic run_vec(vec_t v);
    int i, lat, exp_lat;
    bit bad;
    i = v.inst;
    exp_lat = (v.deg == 0) ? 2 : ((i == 0) ? 32 : 48) + 2;
    send(i, v.pr, v.deg, v.last);
    @(negedge clk); lat = 1;
    chk("busy_in_ready", in_ready[i], 0);
    if (v.last) begin
      while (!out_valid[i] && lat < LIM) begin @(negedge clk); lat++; end
      chk("out_latency", lat, exp_lat);
      chk("out_sum", out_sum[i], v.esum);
      chk("out_count", cnt_of(i), v.ecnt);
      chk("out_zero_deg", out_zero[i], v.ez);
      chk("out_ovf", out_ovf[i], v.eo);
      chk("out_in_ready", in_ready[i], 0);
      if (v.hold > 0) begin
        bad = 0;
        for (int k = 0; k < v.hold; k++) begin
          @(negedge clk);
          if (!out_valid[i] || in_ready[i] || out_sum[i] !== v.esum ||
              cnt_of(i) !== 16'(v.ecnt) || out_ovf[i] !== v.eo || out_zero[i] !== v.ez)
            bad = 1;
        end
        chk("hold_stable", bad, 0);
      end
      out_ready[i] = 1'b1;
      @(posedge clk); #1;
      out_ready[i] = 1'b0;
      @(negedge clk);
      chk("post_out_valid", out_valid[i], 0);
      chk("post_in_ready", in_ready[i], 1);
      chk("post_clear", {cnt_of(i), out_sum[i], out_zero[i], out_ovf[i]}, 0);
    end else begin
      while (!in_ready[i] && lat < LIM) begin @(negedge clk); lat++; end
      chk("tuple_latency", lat, exp_lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 0; in_pr[i] = 0; in_deg[i] = 0; in_last[i] = 0; out_ready[i] = 0;
    end

    // integer mode
    tbl.push_back(mk(0, 6, 2, 1, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 6, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 31, 1, 1, 37, 3, 0, 0, 0));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8, 4, 1, 2, 2, 1, 0, 0));
    tbl.push_back(mk(0, 100, 7, 1, 14, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 32'hFFFFFFFF, 2, 0, 1, 10));
    // Q16.16 mode, 2-bit counter
    tbl.push_back(mk(1, 1, 3, 1, 32'h00005555, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3, 2, 1, 32'h00018000, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 1, 0, 1, 0));
    tbl.push_back(mk(1, 77, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 77, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 77, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 77, 0, 1, 0, 3, 1, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_in_ready", in_ready[i], 1);
      chk("reset_outputs", {out_valid[i], out_sum[i], cnt_of(i), out_zero[i], out_ovf[i]}, 0);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);

    foreach (tbl[k]) run_vec(tbl[k]);

    // Abort a group with reset in the middle of a divide.
    send(0, 1000, 7, 0);
    repeat (5) @(negedge clk);
    chk("mid_div_busy", in_ready[0], 0);
    reset = 1'b0;
    #1;
    chk("abort_in_ready", in_ready[0], 1);
    chk("abort_outputs", {out_valid[0], out_sum[0], cnt0, out_zero[0], out_ovf[0]}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("after_abort_in_ready", in_ready[0], 1);
    chk("after_abort_valid", out_valid[0], 0);
    run_vec(mk(0, 9, 3, 1, 3, 1, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pagerank_reduce_acc.md
Name: pagerank_reduce_acc

Overview:
Streaming PageRank contribution accumulator; generalised successor of the single-shot sum/page_rank/out_deg reduction unit. Accepts a group of (page_rank, out_deg) edge tuples over a valid/ready handshake and divides each sequentially into a fixed-point quotient. It accumulates the group with saturation and emits the group sum with a valid/ready result handshake. It sits between the edge-fetch stream and the rank-update writeback.

Parameters:
WIDTH, 32, width of page_rank, out_deg, out_sum
FRAC_BITS, 16, fractional bits of the quotient and sum (unsigned Q(WIDTH-FRAC_BITS).FRAC_BITS); 0 gives integer mode
CNT_W, 16, width of the per-group edge counter
DAMP, 16'hD99A, damping factor in Q0.16 (0.85); used only with DAMPING_EN
BASE, 0, additive base term in output format; used only with DAMPING_EN

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  edge tuple valid
in_ready  out  1  block can accept a tuple
in_page_rank  in  WIDTH  source page rank, unsigned integer
in_out_deg  in  WIDTH  source out-degree, unsigned integer
in_last  in  1  final tuple of the group
out_valid  out  1  group result valid
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH  accumulated group sum, Q format
out_count  out  CNT_W  tuples in the group (saturates at all-ones)
out_zero_deg  out  1  group contained out_deg==0
out_ovf  out  1  saturation occurred in the group

Behaviour:
- Reset (async assert, synchronous deassert at the top level): state IDLE. All outputs 0 except in_ready=1. Accumulator, counter and flags are cleared.
- States: IDLE, DIV, ACC, DAMP (DAMPING_EN only), OUT.
- IDLE: in_ready=1. A transfer occurs when in_valid&&in_ready. The block latches pr, deg and last, and increments count.
  - If deg!=0, go to DIV.
  - If deg==0, set the sticky zero_deg flag, use quotient 0 and go to ACC.
- DIV: restoring radix-2 divider. Dividend is pr<<FRAC_BITS (QW=WIDTH+FRAC_BITS bits). It produces one quotient bit per cycle, exactly QW cycles. The quotient truncates toward zero. If the quotient exceeds 2^WIDTH-1, it clamps and sets ovf.
- ACC (1 cycle): sum <= sum+q, saturating at 2^WIDTH-1 with ovf set.
  - If last: go to DAMP or OUT.
  - Otherwise go to IDLE.
- OUT: out_valid=1. out_sum, out_count, out_zero_deg and out_ovf are held stable while out_ready=0. When out_valid&&out_ready: clear sum, count and flags, go to IDLE.
- in_ready=0 in every state except IDLE, so new tuples wait under backpressure.
- Latency, deg!=0: tuple accepted at cycle t; ACC at t+QW+1; out_valid at t+QW+2, or t+QW+3 with DAMP.
- Latency, deg==0: out_valid at t+2.
- Throughput: one tuple per QW+2 cycles.
- Reset asserted mid-DIV or mid-OUT aborts the group. No output is produced and in_ready=1 after deassert.
- Counter saturates at 2^CNT_W-1; it does not wrap.

Optional Feature:
PAGERANK_DAMPING_EN
- Defined: the DAMP state (1 cycle) computes out_sum = BASE + ((sum*DAMP)>>16), saturating and setting ovf on overflow. Output latency is +1 cycle.
- Undefined: no DAMP state, no multiplier, out_sum=sum; DAMP and BASE are ignored.

Decomposition:
- pagerank_pkg holds:
  - the state enum (IDLE/DIV/ACC/DAMP/OUT) typedef;
  - a QW localparam function;
  - a saturating-add function;
  - the DAMP Q-format constant.
- One sub-module: seq_divider (start/busy/done, parametrised WIDTH and FRAC_BITS, QW-cycle restoring divide). The top FSM owns the handshake, accumulation and flags.

Test Plan:
- WIDTH=32, FRAC_BITS=0: (pr=6, deg=2, last) -> out_valid 34 cycles after accept; out_sum=3, out_count=1, flags 0.
- FRAC_BITS=0: group (6,2),(6,2),(31,1,last) -> out_sum=37, out_count=3; in_ready low during each DIV.
- FRAC_BITS=16: (pr=1, deg=3, last) -> out_sum=32'h00005555, out_ovf=0.
- FRAC_BITS=0: (5,0),(8,4,last) -> out_sum=2, out_count=2, out_zero_deg=1; the zero-deg tuple takes 2 cycles.
- FRAC_BITS=0: (32'hFFFFFFFF,1),(1,1,last) -> out_sum=32'hFFFFFFFF, out_ovf=1. Hold out_ready=0 for 10 cycles: outputs stable, in_ready=0. Then out_ready=1 clears state.
- Reset pulse mid-DIV of (1000,7) -> all outputs 0, in_ready=1. Next group (9,3,last) -> out_sum=3 with no residue.
